msg_scroller: RTL

MSG_SCROLLER -- requirements
Module: msg_scroller

---
 rtl/msg_scroller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/msg_scroller.sv
// msg_scroller: scrolls a stored message of letter codes (0..9) across four
// 7-segment digit positions.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data message memory write port (codes above 9 rejected)
//   msg_len              message length captured on an accepted start
//   start, stop          single-cycle control pulses (stop wins over start)
//   hold                 level; freezes the scroll timer and pointer
//   code0..code3         registered letter codes, code0 is the leftmost digit
//   dig_en               registered per-digit enable, bit k qualifies codek
//   busy                 high while in SHOW
//   wrap                 one-cycle pulse when the scroll pointer returns to 0
//   wr_err               one-cycle pulse after a rejected write
module msg_scroller #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned DEPTH    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  output logic [5:0] code0,
  output logic [5:0] code1,
  output logic [5:0] code2,
  output logic [5:0] code3,
  output logic [3:0] dig_en,
  output logic       busy,
  output logic       wrap,
  output logic       wr_err
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 6;
  localparam int unsigned LW = 5;
  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ND = 4;

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   len_r, len_nxt;
  logic [AW-1:0]   ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            wrap_nxt;
  logic [DW-1:0]   mem [DEPTH];

  logic            start_ok;
  logic            terminal;
  logic            show_out;
  logic [LW-1:0]   sum   [ND];
  logic [LW-1:0]   idx   [ND];
  logic [DW-1:0]   code_nxt [ND];
  logic [ND-1:0]   dig_nxt;

  assign start_ok = start && (msg_len != '0) && (msg_len <= LW'(DEPTH));
  assign terminal = (cnt == CW'(TICK_DIV - 1));

  // Message memory: survives reset, rejects codes above 9.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && (wr_data <= DW'(9))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_r <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      len_r <= len_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, scroll timer and pointer advance.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_r;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        ptr_nxt = '0;
        if (start_ok) begin
          state_nxt = SHOW;
          len_nxt   = msg_len;
        end
      end
      SHOW: begin
        if (start_ok) begin
          len_nxt = msg_len;
          ptr_nxt = '0;
          cnt_nxt = '0;
        end else if (!hold) begin
          if (terminal) begin
            cnt_nxt = '0;
            // Messages that fit in the window stay static.
            if (len_r > LW'(ND)) begin
              if ({1'b0, ptr} == (len_r - LW'(1))) begin
                ptr_nxt  = '0;
                wrap_nxt = 1'b1;
              end else begin
                ptr_nxt = ptr + AW'(1);
              end
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (stop) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
      cnt_nxt   = '0;
      wrap_nxt  = 1'b0;
    end
  end

  // Window generation; 5-bit sums keep (ptr+k) mod len_r exact at len 16.
  assign show_out = (state == SHOW) && (state_nxt == SHOW);

  always_comb begin
    dig_nxt = '0;
    for (int k = 0; k < ND; k++) begin
      sum[k]      = {1'b0, ptr} + LW'(k);
      idx[k]      = (sum[k] >= len_r) ? (sum[k] - len_r) : sum[k];
      code_nxt[k] = '0;
      if (show_out && (LW'(k) < len_r)) begin
        code_nxt[k] = mem[AW'(idx[k])];
        dig_nxt[k]  = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      code0  <= '0;
      code1  <= '0;
      code2  <= '0;
      code3  <= '0;
      dig_en <= '0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      code0  <= code_nxt[0];
      code1  <= code_nxt[1];
      code2  <= code_nxt[2];
      code3  <= code_nxt[3];
      dig_en <= dig_nxt;
      busy   <= (state_nxt == SHOW);
      wrap   <= wrap_nxt;
      wr_err <= wr_en && (wr_data > DW'(9));
    end
  end

endmodule
